instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/instruction_fetch_unit.sv | 117 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit and its buffer.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  localparam int          DEFAULT_DEPTH    = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: power-of-two ring of {word, pc} entries with flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [63:0]              i_data,
  output logic [63:0]              o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = DEPTH[AW:0];

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [63:0]   r_mem [DEPTH];
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Storage is cleared on reset so the head outputs read as zero until the first push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch FSM, PC and single-outstanding memory request feeding a small instruction buffer.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = DEFAULT_DEPTH
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam int            CW        = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = DEPTH[CW-1:0];

  fetch_state_e  r_state;
  fetch_state_e  w_state_next;
  logic [31:0]   r_pc;
  logic [31:0]   w_pc_next;
  logic [31:0]   r_req_addr;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  fetch_entry_t  w_push_entry;
  fetch_entry_t  w_head;

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_issue      = 1'b0;
    w_push       = 1'b0;
    mem_req      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (redirect_valid) begin
          w_pc_next = align_word(redirect_pc);
        // Gating on reset_n keeps mem_req low while reset is held.
        end else if (reset_n && (w_count < DEPTH_CNT)) begin
          w_issue      = 1'b1;
          mem_req      = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        mem_req = 1'b1;
        if (redirect_valid) begin
          w_pc_next    = align_word(redirect_pc);
          w_state_next = mem_ack ? S_IDLE : S_DROP;
        end else if (mem_ack) begin
          w_push       = ~w_full;
          w_pc_next    = r_pc + 32'd4;
          w_state_next = S_IDLE;
        end
      end
      S_DROP: begin
        mem_req = 1'b1;
        if (redirect_valid) begin
          w_pc_next = align_word(redirect_pc);
        end
        if (mem_ack) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // In DROP the PC may already hold the redirect target, so the bus address comes from r_req_addr.
  assign mem_addr     = (r_state == S_IDLE) ? r_pc : r_req_addr;
  assign w_push_entry = {mem_rdata, r_req_addr};
  assign w_pop        = instr_valid & instr_ready;
  assign instr_valid  = ~w_empty;
  assign instruction  = w_head.word;
  assign instr_pc     = w_head.pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_issue) begin
        r_req_addr <= r_pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_data  (w_push_entry),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed and random stimulus against a queue-based model of the fetch unit's behaviour.
module tb_instruction_fetch_unit;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  bit          m_busy;
  bit          m_drop;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .RESET_PC (RST_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instruction    (instruction),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc   = RST_PC;
    m_addr = RST_PC;
    m_busy = 1'b0;
    m_drop = 1'b0;
  endtask

  // A request is visible while one is outstanding, or when idle with room and no redirect.
  function automatic bit exp_req();
    return m_busy || (!redirect_valid && (m_q.size() < DEPTH));
  endfunction

  task automatic check_reset_values();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, RST_PC);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instruction", instruction, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
  endtask

  task automatic drive(input bit ack, input bit redir, input logic [31:0] rpc, input bit rdy);
    mem_ack        = ack;
    redirect_valid = redir;
    redirect_pc    = rpc;
    instr_ready    = rdy;
    mem_rdata      = (m_busy ? m_addr : m_pc) ^ 32'hA5A5_A5A5;
    #1;
    chk("mem_req", 32'(mem_req), 32'(exp_req()));
    if (exp_req()) chk("mem_addr", mem_addr, m_busy ? m_addr : m_pc);
    chk("instr_valid", 32'(instr_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("instruction", instruction, m_q[0].word);
      chk("instr_pc", instr_pc, m_q[0].pc);
    end
  endtask

  task automatic advance();
    bit   issue;
    ent_t e;
    issue = !m_busy && !redirect_valid && (m_q.size() < DEPTH);
    if ((m_q.size() != 0) && instr_ready) begin
      $display("consume pc=%h word=%h", m_q[0].pc, m_q[0].word);
      m_q.delete(0);
    end
    if (m_busy) begin
      if (mem_ack) begin
        if (!redirect_valid && !m_drop) begin
          e.word = mem_rdata;
          e.pc   = m_addr;
          m_q.push_back(e);
          m_pc = m_pc + 32'd4;
        end
        m_busy = 1'b0;
        m_drop = 1'b0;
      end else if (redirect_valid) begin
        m_drop = 1'b1;
      end
    end else if (issue) begin
      m_busy = 1'b1;
      m_addr = m_pc;
    end
    if (redirect_valid) begin
      m_q.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    mem_ack        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    instr_ready    = 1'b0;
    mem_rdata      = 32'd0;
    #1;
    check_reset_values();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          r_ack;
    bit          r_red;
    bit          r_rdy;
    logic [31:0] r_tgt;

    reset_n = 1'b1;
    #2;

    // Streaming fetch with ack one cycle after each request
    do_reset();
    drive(1, 0, 0, 1); advance();
    drive(1, 0, 0, 1); advance();
    drive(1, 0, 0, 1);
    chk("stream0_pc", instr_pc, 32'h0000_0000);
    chk("stream0_word", instruction, 32'hA5A5_A5A5);
    advance();
    repeat (20) begin drive(1, 0, 0, 1); advance(); end

    // Decoder stalled: buffer fills to DEPTH, then resumes at 0x10
    do_reset();
    repeat (12) begin drive(1, 0, 0, 0); advance(); end
    drive(1, 0, 0, 1);
    chk("full_no_req", 32'(mem_req), 32'd0);
    chk("full_head_pc", instr_pc, 32'h0000_0000);
    advance();
    drive(1, 0, 0, 1);
    chk("resume_addr", mem_addr, 32'h0000_0010);
    advance();
    repeat (10) begin drive(1, 0, 0, 1); advance(); end

    // Redirect while waiting, ack arrives three cycles later
    do_reset();
    drive(0, 0, 0, 1); advance();
    drive(0, 1, 32'h0000_0103, 1); advance();
    drive(0, 0, 0, 1);
    chk("drop_hold_addr", mem_addr, 32'h0000_0000);
    advance();
    drive(0, 0, 0, 1); advance();
    drive(1, 0, 0, 1); advance();
    drive(0, 0, 0, 1);
    chk("drop_next_addr", mem_addr, 32'h0000_0100);
    chk("drop_empty", 32'(instr_valid), 32'd0);
    advance();
    repeat (6) begin drive(1, 0, 0, 1); advance(); end

    // Redirect coinciding with ack
    do_reset();
    drive(0, 0, 0, 1); advance();
    drive(1, 1, 32'h0000_0200, 1); advance();
    drive(0, 0, 0, 1);
    chk("redir_ack_addr", mem_addr, 32'h0000_0200);
    chk("redir_ack_valid", 32'(instr_valid), 32'd0);
    advance();
    repeat (6) begin drive(1, 0, 0, 1); advance(); end

    // PC wrap at the top of the address space
    do_reset();
    drive(1, 1, 32'hFFFF_FFFF, 1); advance();
    drive(1, 0, 0, 1);
    chk("wrap_addr0", mem_addr, 32'hFFFF_FFFC);
    advance();
    drive(1, 0, 0, 1); advance();
    drive(1, 0, 0, 1);
    chk("wrap_addr1", mem_addr, 32'h0000_0000);
    advance();
    repeat (6) begin drive(1, 0, 0, 1); advance(); end

    // Randomised traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r_ack = ($urandom_range(0, 1) == 1);
      r_red = ($urandom_range(0, 19) == 0);
      r_rdy = ($urandom_range(0, 3) != 0);
      r_tgt = $urandom;
      drive(r_ack, r_red, r_tgt, r_rdy);
      advance();
    end

    // Asynchronous reset while a request is outstanding
    do_reset();
    repeat (5) begin drive(1, 0, 0, 0); advance(); end
    drive(0, 0, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    drive(1, 0, 0, 1);
    chk("post_rst_addr", mem_addr, RST_PC);
    chk("post_rst_req", 32'(mem_req), 32'd1);
    advance();
    repeat (8) begin drive(1, 0, 0, 1); advance(); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
